// File: rtl/miner_core_pkg.sv
// Shared state encoding, default SHA-256 round counts and an index-width helper
// for the miner core sequencing logic.
package miner_core_pkg;

  localparam int SHA_MSA_ROUNDS  = 48;
  localparam int SHA_COMP_ROUNDS = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MSA,
    ST_COMP,
    ST_ADD,
    ST_DONE
  } ccu_state_t;

  // Width needed to index n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/miner_core_round_ctr.sv
// Loadable round up-counter (clear > load > increment); last flags count == term.
// Shared between the message-schedule and compression phases.
module miner_core_round_ctr #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         last
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == term);

endmodule

// File: rtl/miner_core_seq_ctrl.sv
// Sequences NUM_PASSES hash passes LOAD -> MSA -> COMP -> ADD with hold/abort; all outputs registered.
// Optional MINER_CCU_PERF_CNT_EN adds a free-running completed-job counter (job_count).
module miner_core_seq_ctrl
  import miner_core_pkg::*;
#(
  parameter  int MSA_ROUNDS  = SHA_MSA_ROUNDS,
  parameter  int COMP_ROUNDS = SHA_COMP_ROUNDS,
  parameter  int NUM_PASSES  = 3,
  localparam int RW = idx_width((MSA_ROUNDS > COMP_ROUNDS) ? MSA_ROUNDS : COMP_ROUNDS),
  localparam int PW = idx_width(NUM_PASSES)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          hash_enable,
  input  logic          hold,
  input  logic          abort,
  output logic          busy,
  output logic          load_en,
  output logic          msa_en,
  output logic          comp_en,
  output logic          add_en,
  output logic [PW-1:0] pass_idx,
  output logic [RW-1:0] round_idx,
  output logic          finished
`ifdef MINER_CCU_PERF_CNT_EN
  ,
  output logic [31:0]   job_count
`endif
);

  localparam logic [RW-1:0] MSA_LAST  = RW'(MSA_ROUNDS - 1);
  localparam logic [RW-1:0] COMP_LAST = RW'(COMP_ROUNDS - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(NUM_PASSES - 1);

  ccu_state_t    state;
  ccu_state_t    state_nxt;
  logic [PW-1:0] pass_nxt;
  logic          active;
  logic          kill;
  logic          stall;
  logic          in_round_phase;
  logic          cnt_en;
  logic          cnt_clr;
  logic          last_round;
  logic [RW-1:0] term;

  assign active         = (state == ST_LOAD) || (state == ST_MSA) ||
                          (state == ST_COMP) || (state == ST_ADD);
  assign kill           = abort && (state != ST_IDLE);
  assign stall          = hold && active && !abort;
  assign in_round_phase = (state == ST_MSA) || (state == ST_COMP);
  assign term           = (state == ST_COMP) ? COMP_LAST : MSA_LAST;

  // The counter runs only inside a phase; it freezes while stalled and is
  // cleared otherwise, so round_idx reads 0 outside MSA/COMP.
  assign cnt_en  = !kill && !stall && in_round_phase && !last_round;
  assign cnt_clr = !cnt_en && !stall;

  miner_core_round_ctr #(
    .W (RW)
  ) u_round_ctr (
    .clk      (clk),
    .n_rst    (n_rst),
    .clr      (cnt_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (cnt_en),
    .term     (term),
    .count    (round_idx),
    .last     (last_round)
  );

  always_comb begin
    state_nxt = state;
    pass_nxt  = pass_idx;
    if (kill) begin
      state_nxt = ST_IDLE;
      pass_nxt  = '0;
    end else if (!stall) begin
      unique case (state)
        ST_IDLE: begin
          if (hash_enable) begin
            state_nxt = ST_LOAD;
            pass_nxt  = '0;
          end
        end
        ST_LOAD: state_nxt = ST_MSA;
        ST_MSA:  if (last_round) state_nxt = ST_COMP;
        ST_COMP: if (last_round) state_nxt = ST_ADD;
        ST_ADD: begin
          if (pass_idx == PASS_LAST) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_LOAD;
            pass_nxt  = pass_idx + 1'b1;
          end
        end
        ST_DONE: begin
          state_nxt = ST_IDLE;
          pass_nxt  = '0;
        end
        default: begin
          state_nxt = ST_IDLE;
          pass_nxt  = '0;
        end
      endcase
    end
  end

  // Outputs are flops decoded from the next state, so a stalled edge yields a
  // cycle with every stage enable low while state and indices stay put.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= ST_IDLE;
      pass_idx <= '0;
      busy     <= 1'b0;
      load_en  <= 1'b0;
      msa_en   <= 1'b0;
      comp_en  <= 1'b0;
      add_en   <= 1'b0;
      finished <= 1'b0;
    end else begin
      state    <= state_nxt;
      pass_idx <= pass_nxt;
      busy     <= (state_nxt != ST_IDLE);
      load_en  <= (state_nxt == ST_LOAD) && !stall;
      msa_en   <= (state_nxt == ST_MSA)  && !stall;
      comp_en  <= (state_nxt == ST_COMP) && !stall;
      add_en   <= (state_nxt == ST_ADD)  && !stall;
      finished <= (state_nxt == ST_DONE);
    end
  end

`ifdef MINER_CCU_PERF_CNT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      job_count <= '0;
    end else if (finished) begin
      job_count <= job_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_miner_core_seq_ctrl.sv
// Directed bench for miner_core_seq_ctrl: default instance plus a 4/8/1 override instance.
module tb_miner_core_seq_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       hash_enable, hold, abort;
  logic       busy, load_en, msa_en, comp_en, add_en, finished;
  logic [1:0] pass_idx;
  logic [5:0] round_idx;
`ifdef MINER_CCU_PERF_CNT_EN
  logic [31:0] job_count;
  logic [31:0] s_job_count;
`endif

  logic       s_hash_enable, s_hold, s_abort;
  logic       s_busy, s_load_en, s_msa_en, s_comp_en, s_add_en, s_finished;
  logic [0:0] s_pass_idx;
  logic [2:0] s_round_idx;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;
  int onehot_bad  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  always @(negedge clk)
    if (n_rst && $countones({load_en, msa_en, comp_en, add_en}) > 1) onehot_bad++;

  miner_core_seq_ctrl u_dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .hash_enable (hash_enable),
    .hold        (hold),
    .abort       (abort),
    .busy        (busy),
    .load_en     (load_en),
    .msa_en      (msa_en),
    .comp_en     (comp_en),
    .add_en      (add_en),
    .pass_idx    (pass_idx),
    .round_idx   (round_idx),
    .finished    (finished)
`ifdef MINER_CCU_PERF_CNT_EN
    ,
    .job_count   (job_count)
`endif
  );

  miner_core_seq_ctrl #(
    .MSA_ROUNDS  (4),
    .COMP_ROUNDS (8),
    .NUM_PASSES  (1)
  ) u_small (
    .clk         (clk),
    .n_rst       (n_rst),
    .hash_enable (s_hash_enable),
    .hold        (s_hold),
    .abort       (s_abort),
    .busy        (s_busy),
    .load_en     (s_load_en),
    .msa_en      (s_msa_en),
    .comp_en     (s_comp_en),
    .add_en      (s_add_en),
    .pass_idx    (s_pass_idx),
    .round_idx   (s_round_idx),
    .finished    (s_finished)
`ifdef MINER_CCU_PERF_CNT_EN
    ,
    .job_count   (s_job_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_job();
    hash_enable = 1'b1;
    @(negedge clk);
    hash_enable = 1'b0;
  endtask

  task automatic wait_point(input bit in_comp, input int p, input int r, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if ((in_comp ? comp_en : msa_en) && int'(pass_idx) == p && int'(round_idx) == r) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_fin(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (finished) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic count_fin(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (finished) seen++;
    end
  endtask

  initial begin
    bit ok;
    int t0, t1, nl, nm, nc, na, dt, seen;
    logic [7:0] exp_v;

    n_rst = 1'b0; hash_enable = 1'b0; hold = 1'b0; abort = 1'b0;
    s_hash_enable = 1'b0; s_hold = 1'b0; s_abort = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_enables", {load_en, msa_en, comp_en, add_en, finished}, 0);
    chk("rst_pass", pass_idx, 0);
    chk("rst_round", round_idx, 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // Baseline job: counts and 342-cycle latency
    start_job();
    chk("t1_first_load", load_en, 1);
    chk("t1_busy", busy, 1);
    nl = 0; nm = 0; nc = 0; na = 0; dt = 0;
    while (!finished && dt < 1000) begin
      nl += int'(load_en); nm += int'(msa_en); nc += int'(comp_en); na += int'(add_en);
      @(negedge clk);
      dt++;
    end
    chk("t1_latency", dt, 342);
    chk("t1_load_cycles", nl, 3);
    chk("t1_msa_cycles", nm, 144);
    chk("t1_comp_cycles", nc, 192);
    chk("t1_add_cycles", na, 3);
    @(negedge clk);
    chk("t1_busy_after", busy, 0);
    chk("t1_fin_pulse", finished, 0);

    // MSA->COMP boundary and a 5-cycle hold in pass 1 COMP round 10
    start_job();
    t0 = cycle;
    wait_point(1'b0, 0, 47, ok);
    chk("t2_msa_last_seen", ok, 1);
    @(negedge clk);
    chk("t2_comp_round0", {msa_en, comp_en, 2'b00, round_idx}, {1'b0, 1'b1, 2'b00, 6'd0});
    wait_point(1'b1, 1, 10, ok);
    chk("t2_hold_point", ok, 1);
    hold = 1'b1;
    @(negedge clk);
    chk("t2_hold_comp_en", comp_en, 0);
    chk("t2_hold_round", round_idx, 10);
    chk("t2_hold_busy", busy, 1);
    repeat (4) @(negedge clk);
    chk("t2_hold_end_round", {comp_en, round_idx}, {1'b0, 6'd10});
    hold = 1'b0;
    @(negedge clk);
    chk("t2_resume", {comp_en, round_idx}, {1'b1, 6'd11});
    wait_fin(1000, ok);
    chk("t2_fin_seen", ok, 1);
    chk("t2_latency", cycle - t0, 347);
    @(negedge clk);

    // Abort in pass 2 MSA round 20
    start_job();
    wait_point(1'b0, 2, 20, ok);
    chk("t3_abort_point", ok, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t3_busy", busy, 0);
    chk("t3_enables", {load_en, msa_en, comp_en, add_en}, 0);
    chk("t3_pass", pass_idx, 0);
    chk("t3_round", round_idx, 0);
    count_fin(400, seen);
    chk("t3_no_finish", seen, 0);
    // start and abort together in IDLE: start wins
    hash_enable = 1'b1; abort = 1'b1;
    @(negedge clk);
    hash_enable = 1'b0; abort = 1'b0;
    chk("t3_start_wins", load_en, 1);
    t0 = cycle;
    wait_fin(1000, ok);
    chk("t3_full_latency", cycle - t0, 342);
    @(negedge clk);

    // hold ignored in IDLE, honoured in LOAD; hash_enable ignored while busy
    hold = 1'b1;
    start_job();
    chk("t4_hold_idle", load_en, 1);
    @(negedge clk);
    chk("t4_hold_load", {load_en, msa_en, busy}, 3'b001);
    hold = 1'b0;
    @(negedge clk);
    chk("t4_msa_start", {msa_en, round_idx}, {1'b1, 6'd0});
    wait_point(1'b1, 0, 5, ok);
    chk("t4_comp_point", ok, 1);
    start_job();
    wait_fin(1000, ok);
    chk("t4_fin_seen", ok, 1);
    count_fin(400, seen);
    chk("t4_one_finish", seen, 0);
    chk("t4_idle", busy, 0);

    // hash_enable held high: back-to-back jobs every 344 cycles
    hash_enable = 1'b1;
    wait_fin(1000, ok);
    t1 = cycle;
    @(negedge clk);
    chk("t5_idle_gap", busy, 0);
    @(negedge clk);
    chk("t5_restart", load_en, 1);
    wait_fin(1000, ok);
    chk("t5_period", cycle - t1, 344);
    hash_enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_stopped", busy, 0);

    // Override instance: LOAD, 4 MSA, 8 COMP, ADD, DONE
    s_hash_enable = 1'b1;
    @(negedge clk);
    s_hash_enable = 1'b0;
    for (int i = 0; i < 15; i++) begin
      exp_v = '0;
      if (i == 0)                exp_v[7] = 1'b1;
      else if (i <= 4)           begin exp_v[6] = 1'b1; exp_v[2:0] = 3'(i - 1); end
      else if (i <= 12)          begin exp_v[5] = 1'b1; exp_v[2:0] = 3'(i - 5); end
      else if (i == 13)          exp_v[4] = 1'b1;
      else                       exp_v[3] = 1'b1;
      chk($sformatf("t6_seq_%0d", i),
          {s_load_en, s_msa_en, s_comp_en, s_add_en, s_finished, s_round_idx}, exp_v);
      @(negedge clk);
    end
    chk("t6_idle", s_busy, 0);

    // Asynchronous reset mid-COMP, away from a clock edge
    start_job();
    wait_point(1'b1, 0, 30, ok);
    chk("t7_point", ok, 1);
    #2 n_rst = 1'b0;
    #1;
    chk("t7_busy", busy, 0);
    chk("t7_comp_en", comp_en, 0);
    chk("t7_round", round_idx, 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
`ifdef MINER_CCU_PERF_CNT_EN
    chk("t8_count_reset", job_count, 0);
    start_job();
    wait_fin(1000, ok);
    @(negedge clk);
    chk("t8_count_1", job_count, 1);
    start_job();
    wait_fin(1000, ok);
    @(negedge clk);
    chk("t8_count_2", job_count, 2);
`endif

    chk("onehot_enables", onehot_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/miner_core_seq_ctrl.md
Name: miner_core_seq_ctrl

Overview:
Parametrised successor to the SHA-256 miner core control unit. Sequences N hash passes through LOAD -> MSA -> COMP -> ADD using its own internal round counter, so no external timer is needed. Adds hold (stall), abort, and exported pass/round indices. Sits between the miner top-level hash request and the msa/compression/adder datapath.

Parameters:
MSA_ROUNDS, 48, message-schedule expansion cycles per pass (>=1)
COMP_ROUNDS, 64, compression rounds per pass (>=1)
NUM_PASSES, 3, passes per job (default: chunk 1, chunk 2, second hash) (>=1)
RW (localparam), $clog2(max(MSA_ROUNDS,COMP_ROUNDS)), round index width (min 1)
PW (localparam), $clog2(NUM_PASSES), pass index width (min 1)

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
hash_enable  in  1  start request, sampled only in IDLE
hold  in  1  stall: freeze state/counters, deassert all stage enables
abort  in  1  cancel job, return to IDLE next edge
busy  out  1  high in any state except IDLE
load_en  out  1  datapath loads chunk/state registers for current pass
msa_en  out  1  message-schedule step enable
comp_en  out  1  compression round enable
add_en  out  1  add working vars into hash state
pass_idx  out  PW  current pass, 0..NUM_PASSES-1
round_idx  out  RW  round within MSA/COMP phase, 0 elsewhere
finished  out  1  one-cycle pulse: job complete

Behaviour:
- Reset (async, n_rst low): state IDLE; all outputs 0; counters 0.
- States: IDLE, LOAD, MSA, COMP, ADD, DONE. Registered FSM; all outputs decoded from registered state and counters (Moore, no combinational input->output path).
- IDLE: hash_enable=1 at an edge -> LOAD, pass_idx=0.
- LOAD: 1 cycle, load_en=1 -> MSA, round=0.
- MSA: msa_en=1 for MSA_ROUNDS cycles, round_idx 0..MSA_ROUNDS-1; at last round -> COMP, round=0.
- COMP: comp_en=1 for COMP_ROUNDS cycles, round_idx 0..COMP_ROUNDS-1 -> ADD.
- ADD: 1 cycle, add_en=1. If pass_idx<NUM_PASSES-1, pass_idx++ and -> LOAD; else -> DONE.
- DONE: 1 cycle, finished=1, busy=1 -> IDLE; pass_idx and round_idx clear.
- Latency with no hold: first load_en one cycle after hash_enable is sampled. finished asserts NUM_PASSES*(MSA_ROUNDS+COMP_ROUNDS+2) cycles after load_en first rises (defaults: 342).
- hold=1 in any non-IDLE, non-DONE state: state, pass_idx and round_idx are frozen; load_en, msa_en, comp_en, add_en are forced to 0; busy stays 1. Each held cycle extends latency by one. hold is ignored in IDLE and DONE.
- abort=1 in any non-IDLE state -> IDLE next edge; counters clear; finished is not pulsed. abort has priority over hold. abort in IDLE has no effect.
- hash_enable while busy: ignored (not queued). hash_enable=1 and abort=1 in IDLE: start wins. hash_enable held high continuously: a new job starts in the cycle after DONE.
- At most one of load_en/msa_en/comp_en/add_en is high in any cycle.
- Counter terminal compares use full RW width; no wrap occurs within a phase.

Optional Feature:
MINER_CCU_PERF_CNT_EN: adds output job_count[31:0]. It increments on each finished pulse, wraps 0xFFFFFFFF->0, is not cleared by abort, and is reset to 0 only by n_rst. Without the macro the port and counter do not exist, and all other behaviour is identical.

Decomposition:
- Package miner_core_pkg: state enum type (ccu_state_t); default round constants SHA_MSA_ROUNDS=48, SHA_COMP_ROUNDS=64.
- Sub-module miner_core_round_ctr: loadable up-counter with clear, enable and a terminal-value compare input, returning a last-round flag. Instantiated once and reused for the MSA and COMP phases.

Test Plan:
- Defaults, single hash_enable pulse: load_en rises 1 cycle later; msa_en high 48 cycles, comp_en 64, add_en 1, repeated ×3; finished 342 cycles after first load_en; busy drops the cycle after finished.
- hold=1 for 5 cycles starting at pass 1 COMP round 10: enables 0, round_idx stays 10; finished is delayed by exactly 5 cycles versus baseline.
- abort at pass 2 MSA round 20: next cycle busy=0, every enable 0, pass_idx=0; finished never pulses; a later hash_enable gives a full 342-cycle job.
- hash_enable pulsed during pass 0 COMP: ignored, only one finished seen. hash_enable held high: back-to-back jobs with finished every 344 cycles (342 run + DONE + IDLE).
- Param override MSA_ROUNDS=4, COMP_ROUNDS=8, NUM_PASSES=1: sequence LOAD, 4 MSA, 8 COMP, ADD, DONE; finished 14 cycles after load_en.
- n_rst asserted mid-COMP, away from a clock edge: outputs go 0 immediately; with MINER_CCU_PERF_CNT_EN defined, job_count is 0 after reset and counts 1, 2 over two completed jobs.
